// File: rtl/det_job_arbiter.sv
// det_job_arbiter: shares one determinant engine among NUM_REQ requesters.
// Round-robin grant, latches the winner's 5x5 byte matrix, runs the engine's
// start/done handshake under a watchdog and returns one response at a time.
// Optional feature: define DET_ARB_STATS_EN to add the stat_jobs/stat_timeouts
// saturating counters and their output ports.
module det_job_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned DET_W          = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*200-1:0]     req_matrix,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [199:0]               eng_matrix,
    output logic                       eng_start,
    output logic                       eng_reset,
    input  logic                       eng_done,
    input  logic [DET_W-1:0]           eng_det,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DET_W-1:0]           rsp_det,
    output logic                       rsp_timeout
`ifdef DET_ARB_STATS_EN
  , output logic [15:0]                stat_jobs,
    output logic [7:0]                 stat_timeouts
`endif
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned MAT_W = 200;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [ID_W-1:0]  RR_RESET  = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StRelease,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [MAT_W-1:0]     eng_matrix_q, eng_matrix_d;
    logic                 eng_start_q, eng_start_d;
    logic                 wd_pulse_q, wd_pulse_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [DET_W-1:0]     rsp_det_q, rsp_det_d;
    logic                 rsp_timeout_q, rsp_timeout_d;

    logic                 win_valid;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      cand;
    logic [MAT_W-1:0]     win_matrix;

    // Round-robin search: first active request after rr_ptr, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's matrix slice.
    always_comb begin
        win_matrix = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_matrix = req_matrix[i*MAT_W +: MAT_W];
            end
        end
    end

    // Job FSM next-state and registered-output next values.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        gnt_d         = '0;
        eng_matrix_d  = eng_matrix_q;
        eng_start_d   = eng_start_q;
        wd_pulse_d    = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_det_d     = rsp_det_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    gnt_d        = NUM_REQ'(1) << win_idx;
                    eng_matrix_d = win_matrix;
                    rsp_id_d     = win_idx;
                    rr_ptr_d     = win_idx;
                    eng_start_d  = 1'b1;
                    timer_d      = '0;
                    state_d      = StLaunch;
                end
            end
            StLaunch: begin
                // eng_done may still be high from the previous job; ignore it here.
                state_d = StWait;
            end
            StWait: begin
                // Done has priority over the watchdog in the same cycle.
                if (eng_done) begin
                    rsp_det_d     = eng_det;
                    rsp_timeout_d = 1'b0;
                    eng_start_d   = 1'b0;
                    state_d       = StRelease;
                end else if (timer_q == TIMER_MAX) begin
                    eng_start_d   = 1'b0;
                    wd_pulse_d    = 1'b1;
                    rsp_det_d     = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StRelease;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StRelease: begin
                // One cycle with start low so the engine can return to idle.
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-job drops the job.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= RR_RESET;
            timer_q       <= '0;
            gnt_q         <= '0;
            eng_matrix_q  <= '0;
            eng_start_q   <= 1'b0;
            wd_pulse_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_det_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            gnt_q         <= gnt_d;
            eng_matrix_q  <= eng_matrix_d;
            eng_start_q   <= eng_start_d;
            wd_pulse_q    <= wd_pulse_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_det_q     <= rsp_det_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign eng_matrix  = eng_matrix_q;
    assign eng_start   = eng_start_q;
    assign eng_reset   = reset | wd_pulse_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_det     = rsp_det_q;
    assign rsp_timeout = rsp_timeout_q;

`ifdef DET_ARB_STATS_EN
    logic [15:0] stat_jobs_q;
    logic [7:0]  stat_timeouts_q;

    // Saturating job / watchdog-abort counters; wd_pulse_q is high once per abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_jobs_q     <= '0;
            stat_timeouts_q <= '0;
        end else begin
            if (state_q == StResp && rsp_ready && stat_jobs_q != 16'hffff) begin
                stat_jobs_q <= stat_jobs_q + 16'd1;
            end
            if (wd_pulse_q && stat_timeouts_q != 8'hff) begin
                stat_timeouts_q <= stat_timeouts_q + 8'd1;
            end
        end
    end

    assign stat_jobs     = stat_jobs_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

    // Grant is one-hot or idle.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

    // Engine start and a pending response never overlap.
    a_start_vs_rsp : assert property (@(posedge clk) disable iff (reset)
        !(eng_start && rsp_valid));

    // A stalled response holds its payload.
    a_rsp_stable : assert property (@(posedge clk) disable iff (reset)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_id) && $stable(rsp_det)
                                    && $stable(rsp_timeout));

endmodule
